// File: rtl/fetch_unit.sv
// Fetch stage of the single-issue RV32 core.
// Owns the program counter, addresses the combinational instruction memory,
// and presents the fetched word to decode through a one-entry IF/ID register.
//
// Handshake: if_valid/if_pc/if_instr form a valid/ready channel towards
// decode. A transfer happens on any rising edge where if_valid && id_ready.
// Once if_valid is high the entry is held stable until it is transferred,
// except that a redirect, a fault or a reset flushes it unconditionally.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instr_addr,
  input  logic [31:0] instr_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        fetch_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] if_pc_d, if_instr_d, fetch_count_d;
  logic        if_valid_d, fetch_fault_d;
  logic        handshake, load, misaligned;

  assign instr_addr = pc;
  assign handshake  = if_valid && id_ready;
  assign load       = (!if_valid || id_ready) && (state == RUN) && !redirect_valid;
  assign misaligned = redirect_pc[1:0] != 2'b00;

  // Next-state and next-register values; everything holds unless a rule fires.
  always_comb begin
    state_d       = state;
    pc_d          = pc;
    if_valid_d    = if_valid;
    if_pc_d       = if_pc;
    if_instr_d    = if_instr;
    fetch_fault_d = fetch_fault;
    // Decode consumes the current entry even if it is flushed on the same edge.
    fetch_count_d = handshake ? fetch_count + 32'd1 : fetch_count;
    case (state)
      RUN: begin
        if (redirect_valid && misaligned) begin
          state_d       = FAULT;
          fetch_fault_d = 1'b1;
          if_valid_d    = 1'b0;
          if_instr_d    = NOP_INSTR;
        end else if (redirect_valid) begin
          // The word fetched from the old pc this cycle is discarded.
          pc_d       = redirect_pc;
          if_valid_d = 1'b0;
          if_instr_d = NOP_INSTR;
        end else if (load) begin
          if_pc_d    = pc;
          if_instr_d = instr_rdata;
          if_valid_d = 1'b1;
          pc_d       = pc + 32'd4;
        end
      end
      FAULT: begin
        // Frozen until reset: no fetch, no redirect, empty IF/ID.
        if_valid_d = 1'b0;
        if_instr_d = NOP_INSTR;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= 32'd0;
      if_instr    <= NOP_INSTR;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_d;
      pc          <= pc_d;
      if_valid    <= if_valid_d;
      if_pc       <= if_pc_d;
      if_instr    <= if_instr_d;
      fetch_fault <= fetch_fault_d;
      fetch_count <= fetch_count_d;
    end
  end

endmodule
